// File: rtl/radius_pkg.sv
// Shared definitions for the player-radius game controller: state encoding,
// default radius bounds and collision-bus layout.
package radius_pkg;

    typedef enum logic [1:0] {
        MENU  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int R_INIT_DEF = 20;
    localparam int R_MIN_DEF  = 10;
    localparam int R_MAX_DEF  = 20;
    localparam int STEP_DEF   = 2;
    localparam int PEND_W_DEF = 3;

    // col[3:0] are shrink sources, col[4] is the single grow source
    localparam logic [4:0] SHRINK_MASK = 5'b01111;
    localparam int         GROW_BIT    = 4;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/radius_sched_rise_detect.sv
// Per-bit rising-edge detector: pulses for one cycle when a level goes 0->1.
module rise_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= '0;
        else        prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/radius_sched.sv
// Game controller for the player radius: menu/run/pause/over FSM, collision
// event capture and one bounded radius step per tick. Option: RADIUS_GAME_OVER_EN.
module radius_sched
    import radius_pkg::*;
#(
    parameter int R_INIT = R_INIT_DEF,
    parameter int R_MIN  = R_MIN_DEF,
    parameter int R_MAX  = R_MAX_DEF,
    parameter int STEP   = STEP_DEF,
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic [4:0] col,
    output logic [5:0] r,
    output logic       gamemenu,
    output logic       gamerun,
    output logic       gamepause,
    output logic       game_over,
    output logic       step_shrink,
    output logic       step_grow
);

    if (!(R_MIN <= R_INIT && R_INIT <= R_MAX && R_MAX <= 63 && STEP >= 1 && STEP <= 63))
    begin : g_param_check
        $error("radius_sched: illegal radius parameters");
    end

    localparam int         SW       = PEND_W + 3;
    localparam logic [6:0] R_MIN7   = 7'(R_MIN);
    localparam logic [6:0] R_MAX7   = 7'(R_MAX);
    localparam logic [6:0] STEP7    = 7'(STEP);
    localparam logic [5:0] R_INIT6  = 6'(R_INIT);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state, state_next;
    logic [1:0]        btn_rise;
    logic [4:0]        col_rise;
    logic [PEND_W-1:0] shrink_pend, grow_pend, shrink_sat, grow_sat;
    logic [SW-1:0]     shrink_sum, grow_sum;
    logic [2:0]        shrink_add;
    logic              grow_add, shrink_take, grow_take;
    logic              shrink_fire, grow_fire;
    logic [5:0]        r_next;
    logic [6:0]        r7;
`ifdef RADIUS_GAME_OVER_EN
    logic              over_hit;
`endif

    rise_detect #(.WIDTH(2)) u_btn_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .level ({btn_pause, btn_start}),
        .rise  (btn_rise)
    );

    rise_detect #(.WIDTH(5)) u_col_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .level (col),
        .rise  (col_rise)
    );

    assign r7 = {1'b0, r};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        shrink_take = 1'b0;
        grow_take   = 1'b0;
        shrink_fire = 1'b0;
        grow_fire   = 1'b0;
        r_next      = r;
`ifdef RADIUS_GAME_OVER_EN
        over_hit    = 1'b0;
`endif
        if (state == RUN && tick) begin
            if (shrink_pend != '0 && grow_pend != '0) begin
                // opposing requests cancel each other
                shrink_take = 1'b1;
                grow_take   = 1'b1;
            end else if (shrink_pend != '0) begin
                shrink_take = 1'b1;
                if (r7 > R_MIN7) begin
                    shrink_fire = 1'b1;
                    r_next      = (r7 < R_MIN7 + STEP7) ? 6'(R_MIN7) : 6'(r7 - STEP7);
                end else begin
`ifdef RADIUS_GAME_OVER_EN
                    over_hit = 1'b1;
`endif
                end
            end else if (grow_pend != '0) begin
                grow_take = 1'b1;
                if (r7 < R_MAX7) begin
                    grow_fire = 1'b1;
                    r_next    = (r7 + STEP7 > R_MAX7) ? 6'(R_MAX7) : 6'(r7 + STEP7);
                end
            end
        end
    end

    // Edges only count in RUN; the tick consumes pre-edge counts in the same cycle.
    assign shrink_add = (state == RUN) ? popcount4(col_rise[3:0] & SHRINK_MASK[3:0]) : 3'd0;
    assign grow_add   = (state == RUN) && col_rise[GROW_BIT];
    assign shrink_sum = SW'(shrink_pend) - SW'(shrink_take) + SW'(shrink_add);
    assign grow_sum   = SW'(grow_pend) - SW'(grow_take) + SW'(grow_add);
    assign shrink_sat = (shrink_sum > SW'(PEND_MAX)) ? PEND_MAX : shrink_sum[PEND_W-1:0];
    assign grow_sat   = (grow_sum > SW'(PEND_MAX)) ? PEND_MAX : grow_sum[PEND_W-1:0];

    always_comb begin
        state_next = state;
        case (state)
            MENU:  if (btn_rise[0]) state_next = RUN;
            RUN: begin
`ifdef RADIUS_GAME_OVER_EN
                if (over_hit)          state_next = OVER;
                else
`endif
                if (btn_rise[1])       state_next = PAUSE;
            end
            PAUSE: begin
                if (btn_rise[0])       state_next = MENU;
                else if (btn_rise[1])  state_next = RUN;
            end
            OVER:  if (btn_rise[0]) state_next = MENU;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MENU;
            r           <= R_INIT6;
            shrink_pend <= '0;
            grow_pend   <= '0;
            step_shrink <= 1'b0;
            step_grow   <= 1'b0;
            gamemenu    <= 1'b1;
            gamerun     <= 1'b0;
            gamepause   <= 1'b0;
        end else begin
            state       <= state_next;
            step_shrink <= shrink_fire;
            step_grow   <= grow_fire;
            gamemenu    <= (state_next == MENU);
            gamerun     <= (state_next == RUN);
            gamepause   <= (state_next == PAUSE);
            // Entering (or sitting in) MENU prepares a fresh game
            if (state_next == MENU) begin
                r           <= R_INIT6;
                shrink_pend <= '0;
                grow_pend   <= '0;
            end else begin
                r           <= r_next;
                shrink_pend <= shrink_sat;
                grow_pend   <= grow_sat;
            end
        end
    end

`ifdef RADIUS_GAME_OVER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) game_over <= 1'b0;
        else        game_over <= (state_next == OVER);
    end
`else
    assign game_over = 1'b0;
`endif

endmodule

// File: tb/tb_radius_sched.sv
// Self-checking bench for radius_sched: directed scenarios plus random stimulus
// against a behavioural game model. Honours RADIUS_GAME_OVER_EN.
module tb_radius_sched;

    localparam int R_INIT = 20;
    localparam int R_MIN  = 10;
    localparam int R_MAX  = 20;
    localparam int STEP   = 2;
    localparam int PMAX   = 7;
    localparam int M_MENU = 0, M_RUN = 1, M_PAUSE = 2, M_OVER = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, btn_start, btn_pause;
    logic [4:0] col;
    logic [5:0] r;
    logic       gamemenu, gamerun, gamepause, game_over, step_shrink, step_grow;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    int   m_st, m_r, m_sp, m_gp;
    logic m_ps, m_pp, m_fs, m_fg;
    logic [4:0] m_pc;

    radius_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .btn_start   (btn_start),
        .btn_pause   (btn_pause),
        .col         (col),
        .r           (r),
        .gamemenu    (gamemenu),
        .gamerun     (gamerun),
        .gamepause   (gamepause),
        .game_over   (game_over),
        .step_shrink (step_shrink),
        .step_grow   (step_grow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_MENU; m_r = R_INIT; m_sp = 0; m_gp = 0;
        m_ps = 0; m_pp = 0; m_pc = '0; m_fs = 0; m_fg = 0;
    endtask

    task automatic model_step(input logic s, input logic p, input logic [4:0] c, input logic t);
        logic se, pe;
        logic [4:0] ce;
        int ns, ng, cs, cg;
        bit over;
        se = s & ~m_ps;
        pe = p & ~m_pp;
        ce = c & ~m_pc;
        m_ps = s; m_pp = p; m_pc = c;
        m_fs = 0; m_fg = 0; over = 0; cs = 0; cg = 0;
        case (m_st)
            M_RUN: begin
                ns = int'(ce[0]) + int'(ce[1]) + int'(ce[2]) + int'(ce[3]);
                ng = int'(ce[4]);
                if (t) begin
                    if (m_sp > 0 && m_gp > 0) begin
                        cs = 1; cg = 1;
                    end else if (m_sp > 0) begin
                        cs = 1;
                        if (m_r > R_MIN) begin
                            m_r = (m_r - STEP < R_MIN) ? R_MIN : m_r - STEP;
                            m_fs = 1;
                        end else begin
`ifdef RADIUS_GAME_OVER_EN
                            over = 1;
`endif
                        end
                    end else if (m_gp > 0) begin
                        cg = 1;
                        if (m_r < R_MAX) begin
                            m_r = (m_r + STEP > R_MAX) ? R_MAX : m_r + STEP;
                            m_fg = 1;
                        end
                    end
                end
                m_sp = (m_sp - cs + ns > PMAX) ? PMAX : m_sp - cs + ns;
                m_gp = (m_gp - cg + ng > PMAX) ? PMAX : m_gp - cg + ng;
                if (over)    m_st = M_OVER;
                else if (pe) m_st = M_PAUSE;
            end
            M_PAUSE: if (se) m_st = M_MENU; else if (pe) m_st = M_RUN;
            M_MENU:  if (se) m_st = M_RUN;
            default: if (se) m_st = M_MENU;
        endcase
        if (m_st == M_MENU) begin
            m_r = R_INIT; m_sp = 0; m_gp = 0;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".r"}, r, m_r);
        check({tag, ".flags"}, {gamemenu, gamerun, gamepause, game_over},
              {m_st == M_MENU, m_st == M_RUN, m_st == M_PAUSE, m_st == M_OVER});
        check({tag, ".steps"}, {step_shrink, step_grow}, {m_fs, m_fg});
    endtask

    task automatic cyc(input logic s, input logic p, input logic [4:0] c, input logic t);
        @(negedge clk);
        btn_start = s; btn_pause = p; col = c; tick = t;
        model_step(s, p, c, t);
        @(posedge clk);
        #1;
        compare_model("cyc");
    endtask

    task automatic idle(); cyc(0, 0, 5'd0, 0); endtask
    task automatic start_edge(); cyc(1, 0, 5'd0, 0); idle(); endtask
    task automatic pause_edge(); cyc(0, 1, 5'd0, 0); idle(); endtask
    task automatic col_edge(input logic [4:0] c); cyc(0, 0, c, 0); idle(); endtask
    task automatic do_tick(); cyc(0, 0, 5'd0, 1); endtask

    // Pause then start returns to MENU, another start begins a fresh game
    task automatic restart();
        pause_edge();
        start_edge();
        start_edge();
    endtask

    initial begin
        logic s, p, t;
        logic [4:0] c;
        rst_n = 1'b0; tick = 0; btn_start = 0; btn_pause = 0; col = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset.r", r, R_INIT);
        check("reset.flags", {gamemenu, gamerun, gamepause, game_over}, 4'b1000);
        check("reset.steps", {step_shrink, step_grow}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // start, then three shrinks
        cyc(1, 0, 5'd0, 0);
        check("start.gamerun", gamerun, 1);
        check("start.r", r, 20);
        idle();
        for (int i = 0; i < 3; i++) col_edge(5'b00001);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            check("shrink.r", r, 18 - 2 * i);
            check("shrink.pulse", step_shrink, 1);
        end

        // grow at R_MAX is discarded and consumed
        restart();
        check("restart.r", r, 20);
        col_edge(5'b10000);
        do_tick();
        check("grow_max.r", r, 20);
        check("grow_max.pulse", step_grow, 0);
        col_edge(5'b00001);
        do_tick();
        check("grow_consumed.r", r, 18);

        // shrink and grow cancel
        col_edge(5'b10010);
        do_tick();
        check("cancel.r", r, 18);
        check("cancel.steps", {step_shrink, step_grow}, 0);
        do_tick();
        check("cancel2.r", r, 18);
        col_edge(5'b10000);
        do_tick();
        check("cancel_cleared.r", r, 20);

        // saturation at 7 and the min bound
        for (int i = 0; i < 9; i++) col_edge(5'b00100);
        for (int i = 0; i < 7; i++) do_tick();
`ifdef RADIUS_GAME_OVER_EN
        check("min.over", game_over, 1);
        check("min.r", r, 10);
        start_edge();
        check("over_exit.menu", gamemenu, 1);
        start_edge();
`else
        check("min.r", r, 10);
        check("min.over", game_over, 0);
        col_edge(5'b10000);
        do_tick();
        check("sat.r", r, 12);
        restart();
`endif

        // pause holds counters, ticks ignored while paused
        col_edge(5'b00001);
        col_edge(5'b00001);
        pause_edge();
        do_tick();
        do_tick();
        check("pause.r", r, 20);
        pause_edge();
        do_tick();
        check("resume.r", r, 18);
        pause_edge();
        start_edge();
        check("pause_start.menu", gamemenu, 1);
        start_edge();
        check("newgame.r", r, 20);
        do_tick();
        check("newgame_cleared.r", r, 20);

        // asynchronous reset mid-game
        for (int i = 0; i < 3; i++) col_edge(5'b00001);
        for (int i = 0; i < 3; i++) do_tick();
        check("pre_reset.r", r, 14);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset.r", r, 20);
        check("async_reset.menu", gamemenu, 1);
        check("async_reset.run", gamerun, 0);
        btn_start = 0; btn_pause = 0; col = '0; tick = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // random play against the model
        s = 0; p = 0; c = '0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(59) == 0) s = ~s;
            if ($urandom_range(39) == 0) p = ~p;
            c = c ^ (5'($urandom) & 5'($urandom) & 5'($urandom));
            t = ($urandom_range(3) == 0);
            cyc(s, p, c, t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
